// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract datapath: operation codes,
// per-stage control payload and the segment-width helper.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Control half of a stage payload; operand and partial-sum vectors live
  // beside it because their width follows the top-level WIDTH parameter.
  typedef struct packed {
    logic valid;
    logic sub;
    logic carry;
    logic zero;
    logic ovf;
  } stage_ctl_t;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/cla_group.sv
// BLOCK-wide carry-lookahead adder group; exposes the carry into its top bit
// so the final group of a word can form the signed-overflow flag.
module cla_group #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  input  logic             i_cin,
  output logic [BLOCK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_c_msb
);

  logic [BLOCK-1:0] w_g;
  logic [BLOCK-1:0] w_p;
  logic [BLOCK:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is a flat sum of generate terms gated by the propagates above them.
  always_comb begin
    logic w_run;
    logic w_acc;
    w_c    = '0;
    w_run  = 1'b1;
    w_acc  = 1'b0;
    w_c[0] = i_cin;
    for (int i = 0; i < BLOCK; i++) begin
      w_run = 1'b1;
      w_acc = 1'b0;
      for (int j = i; j >= 0; j--) begin
        w_acc = w_acc | (w_run & w_g[j]);
        w_run = w_run & w_p[j];
      end
      w_c[i+1] = w_acc | (w_run & i_cin);
    end
  end

  assign o_sum   = w_p ^ w_c[BLOCK-1:0];
  assign o_cout  = w_c[BLOCK];
  assign o_c_msb = w_c[BLOCK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: WIDTH bits split into STAGES registered segments of
// BLOCK-wide CLA groups, behind a bubble-collapsing valid/ready pipeline.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int BLOCK  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int SW = seg_width(WIDTH, STAGES);
  localparam int NG = SW / BLOCK;

  stage_ctl_t       r_ctl    [STAGES];
  logic [WIDTH-1:0] r_a      [STAGES];
  logic [WIDTH-1:0] r_b      [STAGES];
  logic [WIDTH-1:0] r_sum    [STAGES];

  stage_ctl_t       w_ctl_nx [STAGES];
  logic [WIDTH-1:0] w_a_nx   [STAGES];
  logic [WIDTH-1:0] w_b_nx   [STAGES];
  logic [WIDTH-1:0] w_sum_nx [STAGES];
  logic [STAGES:0]  w_ready;

  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_ready[k] = !r_ctl[k].valid || w_ready[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_sum_in;
    logic             w_valid_in;
    logic             w_sub_in;
    logic             w_cin_in;
    logic             w_zero_in;
    logic [SW-1:0]    w_a_seg;
    logic [SW-1:0]    w_b_seg;
    logic [SW-1:0]    w_s;
    logic             w_cmsb [NG];
    logic             w_cout;

    if (k == 0) begin : g_in
      // Subtract is a + ~b + ~borrow_in, so the carry-in flips with the mode.
      assign w_a_in     = a;
      assign w_b_in     = b;
      assign w_sum_in   = '0;
      assign w_valid_in = in_valid;
      assign w_sub_in   = sub;
      assign w_cin_in   = (sub == OP_SUB) ? ~cin : cin;
      assign w_zero_in  = 1'b1;
    end else begin : g_fwd
      assign w_a_in     = r_a[k-1];
      assign w_b_in     = r_b[k-1];
      assign w_sum_in   = r_sum[k-1];
      assign w_valid_in = r_ctl[k-1].valid;
      assign w_sub_in   = r_ctl[k-1].sub;
      assign w_cin_in   = r_ctl[k-1].carry;
      assign w_zero_in  = r_ctl[k-1].zero;
    end

    assign w_a_seg = w_a_in[k*SW +: SW];
    assign w_b_seg = (w_sub_in == OP_ADD) ? w_b_in[k*SW +: SW] : ~w_b_in[k*SW +: SW];

    for (genvar g = 0; g < NG; g++) begin : g_cla
      logic w_ci;
      logic w_co;
      if (g == 0) begin : g_first
        assign w_ci = w_cin_in;
      end else begin : g_next
        assign w_ci = g_cla[g-1].w_co;
      end
      cla_group #(.BLOCK(BLOCK)) u_cla (
        .i_a     (w_a_seg[g*BLOCK +: BLOCK]),
        .i_b     (w_b_seg[g*BLOCK +: BLOCK]),
        .i_cin   (w_ci),
        .o_sum   (w_s[g*BLOCK +: BLOCK]),
        .o_cout  (w_co),
        .o_c_msb (w_cmsb[g])
      );
    end

    assign w_cout      = g_cla[NG-1].w_co;
    assign w_ctl_nx[k] = '{valid: w_valid_in,
                           sub:   w_sub_in,
                           carry: w_cout,
                           zero:  w_zero_in && (w_s == '0),
                           ovf:   w_cmsb[NG-1] ^ w_cout};
    assign w_a_nx[k]   = w_a_in;
    assign w_b_nx[k]   = w_b_in;
    assign w_sum_nx[k] = w_sum_in | (WIDTH'(w_s) << (k * SW));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_ctl[k] <= '0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_ready[k]) begin
          r_ctl[k] <= w_ctl_nx[k];
          r_a[k]   <= w_a_nx[k];
          r_b[k]   <= w_b_nx[k];
          r_sum[k] <= w_sum_nx[k];
        end
      end
    end
  end

  assign in_ready  = w_ready[0];
  assign out_valid = r_ctl[STAGES-1].valid;
  assign sum       = r_sum[STAGES-1];
  assign carry     = r_ctl[STAGES-1].carry;
  assign overflow  = r_ctl[STAGES-1].ovf;
  assign zero      = r_ctl[STAGES-1].zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed corner cases, a randomized stalled
// stream checked against a signed/unsigned arithmetic model, and mid-flight reset.
module tb_pipelined_addsub;

  localparam int W = 32;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry;
  logic         overflow;
  logic         zero;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  res_t exp_q[$];

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .STAGES(S), .BLOCK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  // Reference: signed result range decides overflow, unsigned magnitude decides carry.
  function automatic res_t model(input logic [31:0] ta, input logic [31:0] tb_,
                                 input logic tc, input logic ts);
    res_t   r;
    longint sa, sb, sr, ua, ub, ci;
    sa = longint'($signed(ta));
    sb = longint'($signed(tb_));
    ua = longint'({32'b0, ta});
    ub = longint'({32'b0, tb_});
    ci = tc ? 64'sd1 : 64'sd0;
    if (ts) begin
      sr  = sa - sb - ci;
      r.c = (ua >= ub + ci);
      r.s = 32'(ua - ub - ci);
    end else begin
      sr  = sa + sb + ci;
      r.c = ((ua + ub + ci) > 64'sd4294967295);
      r.s = 32'(ua + ub + ci);
    end
    r.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.z = (r.s == 32'h0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One op with no backpressure: not visible after 1 cycle, visible after 2.
  task automatic directed(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic tc, input logic ts, input logic [31:0] es,
                          input logic ec, input logic ev, input logic ez);
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb_; cin = tc; sub = ts; out_ready = 1'b1;
    #1;
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk1({tag, "_early"}, out_valid, 1'b0);
    @(negedge clk);
    #1;
    chk1({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_sum"}, sum, es);
    chk1({tag, "_carry"}, carry, ec);
    chk1({tag, "_ovf"}, overflow, ev);
    chk1({tag, "_zero"}, zero, ez);
  endtask

  initial begin
    logic [31:0] op_a, op_b, p_sum;
    logic        op_c, op_s, pending, prev_stall, p_c, p_v, p_z, acc, ret;
    int          issued, retired, occ;
    res_t        m, e;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;

    // Reset held for two edges.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk1("post_rst_out_valid", out_valid, 1'b0);
    chk1("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_sum", sum, 32'h0);
    chk1("post_rst_carry", carry, 1'b0);
    chk1("post_rst_ovf", overflow, 1'b0);
    chk1("post_rst_zero", zero, 1'b0);

    directed("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    directed("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed("sub_neg", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    directed("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    directed("seg_b", 32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    directed("seg_cin", 32'h0000_FFFF, 32'h0, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    directed("sub_borrow", 32'h0000_0003, 32'h0000_0003, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

    // Randomized stream with a 3-cycle output stall.
    issued = 0; retired = 0; occ = 0; pending = 1'b0; prev_stall = 1'b0;
    op_a = '0; op_b = '0; op_c = 1'b0; op_s = 1'b0;
    p_sum = '0; p_c = 1'b0; p_v = 1'b0; p_z = 1'b0;
    for (int cyc = 0; cyc < 100 && retired < 8; cyc++) begin
      @(negedge clk);
      if (!pending && issued < 8) begin
        op_a = $urandom; op_b = $urandom;
        op_c = 1'($urandom_range(0, 1)); op_s = 1'($urandom_range(0, 1));
        if (issued == 2) op_b = op_a;
        pending = 1'b1;
      end
      in_valid = pending; a = op_a; b = op_b; cin = op_c; sub = op_s;
      out_ready = !(cyc >= 3 && cyc < 6);
      #1;
      chk1("stream_in_ready", in_ready, out_ready || (occ < S));
      if (occ == 0) chk1("stream_idle_valid", out_valid, 1'b0);
      if (prev_stall) begin
        chk1("stall_valid", out_valid, 1'b1);
        chk("stall_sum", sum, p_sum);
        chk1("stall_carry", carry, p_c);
        chk1("stall_ovf", overflow, p_v);
        chk1("stall_zero", zero, p_z);
      end
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      if (ret) begin
        if (exp_q.size() == 0) begin
          chk1("stream_extra_result", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("stream_sum", sum, e.s);
          chk1("stream_carry", carry, e.c);
          chk1("stream_ovf", overflow, e.v);
          chk1("stream_zero", zero, e.z);
        end
        retired++;
        occ--;
      end
      if (acc) begin
        m = model(op_a, op_b, op_c, op_s);
        exp_q.push_back(m);
        issued++;
        occ++;
        pending = 1'b0;
      end
      prev_stall = out_valid && !out_ready;
      p_sum = sum; p_c = carry; p_v = overflow; p_z = zero;
    end
    in_valid = 1'b0;
    chk("stream_retired", 32'(retired), 32'd8);
    chk("stream_leftover", 32'(exp_q.size()), 32'd0);

    // Reset with two operations in flight and the output blocked.
    @(negedge clk);
    in_valid = 1'b1; a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    a = 32'h3333_3333; b = 32'h4444_4444;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk1("pre_rst_inflight", out_valid, 1'b1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk1("no_stale_result", out_valid, 1'b0);
    end
    directed("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
